// File: rtl/bip_dmem_pkg.sv
// rtl/bip_dmem_pkg.sv - BIP data memory constants, word/address types and clear-FSM state codes
package bip_dmem_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] dmem_addr_t;
    typedef logic [DATA_W-1:0] dmem_word_t;

    localparam logic [0:0] CLR_IDLE  = 1'b0;
    localparam logic [0:0] CLR_CLEAR = 1'b1;

endpackage

// File: rtl/dmem_clear_fsm.sv
// rtl/dmem_clear_fsm.sv - post-reset zero-fill sweep sequencer (used with DMEM_CLEAR_ON_RESET_EN)
module dmem_clear_fsm
    import bip_dmem_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    output dmem_addr_t       clr_addr,
    output logic             clr_we,
    output logic             busy
);

    logic [0:0] state;

    // Reset parks the sweep at address 0; it starts on the first edge after release.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLR_CLEAR;
            clr_addr <= '0;
        end else if (state == CLR_CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
            if (clr_addr == dmem_addr_t'(DEPTH - 1))
                state <= CLR_IDLE;
        end
    end

    assign busy   = (state == CLR_CLEAR);
    assign clr_we = (state == CLR_CLEAR) && !reset;

endmodule

// File: rtl/bip_data_memory.sv
// rtl/bip_data_memory.sv - BIP 2048x16 single-port data RAM, registered read; optional zero-fill via DMEM_CLEAR_ON_RESET_EN
import bip_dmem_pkg::*;

module bip_data_memory #(
    parameter int ADDR_W = bip_dmem_pkg::ADDR_W,
    parameter int DATA_W = bip_dmem_pkg::DATA_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RdRam,
    input  logic              WrRam,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] In_Data,
    output logic [DATA_W-1:0] Out_Data,
    output logic              Busy
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

`ifdef DMEM_CLEAR_ON_RESET_EN
    dmem_addr_t clr_addr;
    logic       clr_we;

    dmem_clear_fsm u_clear_fsm (
        .clk      (clk),
        .reset    (reset),
        .clr_addr (clr_addr),
        .clr_we   (clr_we),
        .busy     (busy)
    );

    // The sweep owns the write port while busy; the external port is ignored.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = Addr;
        mem_wdata = In_Data;
        if (reset) begin
            mem_we = 1'b0;
        end else if (busy) begin
            mem_we    = clr_we;
            mem_waddr = ADDR_W'(clr_addr);
            mem_wdata = '0;
        end else begin
            mem_we = WrRam;
        end
    end
`else
    assign busy = 1'b0;

    always_comb begin
        mem_we    = WrRam && !reset;
        mem_waddr = Addr;
        mem_wdata = In_Data;
    end
`endif

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    // Write-first: a simultaneous read returns the word being written.
    always_ff @(posedge clk) begin
        if (reset) begin
            Out_Data <= '0;
        end else if (!busy && RdRam) begin
            Out_Data <= WrRam ? In_Data : mem[Addr];
        end
    end

    assign Busy = busy;

endmodule

// File: tb/tb_bip_data_memory.sv
// tb/tb_bip_data_memory.sv - self-checking bench for bip_data_memory against an array reference model
module tb_bip_data_memory;

    localparam int AW = 11;
    localparam int DW = 16;
    localparam int N  = 2048;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          RdRam = 1'b0;
    logic          WrRam = 1'b0;
    logic [AW-1:0] Addr = '0;
    logic [DW-1:0] In_Data = '0;
    logic [DW-1:0] Out_Data;
    logic          Busy;

    logic [DW-1:0] model [N];
    logic [DW-1:0] exp_out = '0;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    bip_data_memory dut (
        .clk      (clk),
        .reset    (reset),
        .RdRam    (RdRam),
        .WrRam    (WrRam),
        .Addr     (Addr),
        .In_Data  (In_Data),
        .Out_Data (Out_Data),
        .Busy     (Busy)
    );

    task automatic check_out(input string tag);
        checks++;
        assert (Out_Data === exp_out) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, Out_Data, exp_out);
        end
    endtask

    task automatic check_busy(input string tag, input logic expected);
        checks++;
        assert (Busy === expected) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, Busy, expected);
        end
    endtask

    // One clock with the given port values; the model applies the memory rules afterwards.
    task automatic cycle(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        RdRam = rd; WrRam = wr; Addr = a; In_Data = d;
        @(posedge clk); #1;
        if (reset) begin
            exp_out = '0;
        end else begin
            if (rd) exp_out = wr ? d : model[a];
            if (wr) model[a] = d;
        end
        RdRam = 1'b0; WrRam = 1'b0;
    endtask

    task automatic access(input string tag, input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cycle(rd, wr, a, d);
        check_out(tag);
    endtask

    task automatic do_reset();
        int n;
        reset = 1'b1;
        cycle(1'b1, 1'b1, 11'h100, 16'hDEAD);
        cycle(1'b0, 1'b0, 11'h000, 16'h0000);
        check_out("out_in_reset");
`ifdef DMEM_CLEAR_ON_RESET_EN
        check_busy("busy_in_reset", 1'b1);
`else
        check_busy("busy_in_reset", 1'b0);
`endif
        reset = 1'b0;
`ifdef DMEM_CLEAR_ON_RESET_EN
        n = 0;
        while (Busy === 1'b1 && n < 3000) begin
            n++;
            if (n == 300) begin
                RdRam = 1'b1; WrRam = 1'b1; Addr = 11'h100; In_Data = 16'h1111;
            end
            @(posedge clk); #1;
            RdRam = 1'b0; WrRam = 1'b0;
        end
        checks++;
        assert (n == N) else begin
            errors++;
            $error("FAIL sweep_len observed=%0d expected=%0d", n, N);
        end
        for (int i = 0; i < N; i++) model[i] = '0;
        exp_out = '0;
        check_out("out_after_sweep");
`else
        n = 0;
`endif
    endtask

    initial begin
        for (int i = 0; i < N; i++) model[i] = '0;

        do_reset();
`ifndef DMEM_CLEAR_ON_RESET_EN
        // No sweep in this build: establish the all-zero contents through the port.
        for (int i = 0; i < N; i++) cycle(1'b0, 1'b1, AW'(i), 16'h0000);
`endif

        access("rd_7ff_init", 1'b1, 1'b0, 11'h7FF, 16'h0000);
        access("wr_007", 1'b0, 1'b1, 11'h007, 16'hFF00);
        access("rd_007", 1'b1, 1'b0, 11'h007, 16'h0000);
        checks++;
        assert (Out_Data === 16'hFF00) else begin
            errors++;
            $error("FAIL rd_007_const observed=%h expected=%h", Out_Data, 16'hFF00);
        end
        access("hold", 1'b0, 1'b0, 11'h000, 16'h0000);
        access("wr_first_010", 1'b1, 1'b1, 11'h010, 16'h1234);
        access("rd_010", 1'b1, 1'b0, 11'h010, 16'h0000);
        access("wr_000", 1'b0, 1'b1, 11'h000, 16'hAAAA);
        access("wr_7ff", 1'b0, 1'b1, 11'h7FF, 16'h5555);
        access("rd_000", 1'b1, 1'b0, 11'h000, 16'h0000);
        access("rd_7ff", 1'b1, 1'b0, 11'h7FF, 16'h0000);

        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] a;
            logic [3:0]    sel;
            sel = 4'($urandom_range(0, 15));
            a = (sel < 8) ? AW'({sel[2], 7'h00, sel[1:0]} ^ {sel[2], 10'h000})
                          : AW'($urandom_range(0, N - 1));
            access("random", 1'($urandom), 1'($urandom), a, 16'($urandom));
        end

        access("wr_100", 1'b0, 1'b1, 11'h100, 16'hBEEF);
        do_reset();
        access("rd_100_post_reset", 1'b1, 1'b0, 11'h100, 16'h0000);
        access("rd_7ff_post_reset", 1'b1, 1'b0, 11'h7FF, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
